key_event_encoder: RTL and testbench

//   Consumes the debounced per-key pressed levels (1 = pressed) from the Debounce_Single bank.

---
 rtl/key_event_encoder.sv | 173 +++++++++++++++++
 tb/tb_key_event_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Turns debounced key presses into key codes queued in a small first-word fall-through FIFO.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module key_event_encoder #(
  parameter int unsigned NKEYS      = 16,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned HOLD_CYC   = 500,
  parameter int unsigned REPEAT_CYC = 100
) (
  input  logic              clk_1000hz,
  input  logic              rst_n,
  input  logic [NKEYS-1:0]  pressed,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PtrW  = AW + 1;

  typedef enum logic [1:0] {StIdle, StHeld, StWaitAll} state_e;

  state_e              state_q;
  logic [NKEYS-1:0]    pressed_q;
  logic [CODE_W-1:0]   held_idx_q;
  logic                init_q;

  logic [NKEYS-1:0]    rise;
  logic [CODE_W-1:0]   sel;
  logic                held_down;
  logic                push;
  logic [CODE_W-1:0]   push_code;

`ifdef KEY_REPEAT_EN
  localparam int unsigned CntMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [CntW-1:0] cnt_q;
  logic            first_q;
  logic            rep_hit;

  assign rep_hit = first_q ? (cnt_q == CntW'(HOLD_CYC - 1)) : (cnt_q == CntW'(REPEAT_CYC - 1));
`endif

  always_comb begin
    rise = pressed & ~pressed_q;
    sel  = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (rise[i]) sel = CODE_W'(i);
    end
  end

  assign held_down = pressed[held_idx_q];

  always_comb begin
    push      = 1'b0;
    push_code = sel;
    unique case (state_q)
      StIdle: push = init_q && (rise != '0);
`ifdef KEY_REPEAT_EN
      StHeld: begin
        push_code = held_idx_q;
        push      = held_down && rep_hit;
      end
`endif
      default: push = 1'b0;
    endcase
  end

  // The first clock after reset only observes: keys already down must be released first.
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pressed_q  <= '0;
      held_idx_q <= '0;
      init_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
      cnt_q      <= '0;
      first_q    <= 1'b1;
`endif
    end else begin
      pressed_q <= pressed;
      init_q    <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!init_q) begin
            if (pressed != '0) state_q <= StWaitAll;
          end else if (rise != '0) begin
            state_q    <= StHeld;
            held_idx_q <= sel;
`ifdef KEY_REPEAT_EN
            cnt_q      <= '0;
            first_q    <= 1'b1;
`endif
          end
        end
        StHeld: begin
          if (!held_down) begin
            state_q <= (pressed == '0) ? StIdle : StWaitAll;
`ifdef KEY_REPEAT_EN
            cnt_q   <= '0;
            first_q <= 1'b1;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (rep_hit) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
          end else if (cnt_q != CntW'(CntMax)) begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StWaitAll: begin
          if (pressed == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              overflow_q;
  logic              full, pop, push_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = key_valid_q && key_ready;
  assign push_ok = push && (!full || pop);

  // Outputs are registered from the post-edge head so a push into an empty FIFO shows at once.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + (push_ok ? PtrW'(1) : PtrW'(0));
    rd_ptr_d    = rd_ptr_q + (pop ? PtrW'(1) : PtrW'(0));
    key_valid_d = (rd_ptr_d != wr_ptr_d);
    if (push_ok && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
      key_code_d = push_code;
    end else begin
      key_code_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_1000hz) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_code;
  end

  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed vector bench for key_event_encoder: press/lock-out, FIFO fill/overflow, reset, repeat.
module tb_key_event_encoder;

  logic        clk_1000hz = 1'b0;
  logic        rst_n;
  logic [15:0] pressed;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  key_event_encoder #(
    .NKEYS(16), .CODE_W(4), .DEPTH(4), .HOLD_CYC(5), .REPEAT_CYC(3)
  ) dut (
    .clk_1000hz(clk_1000hz),
    .rst_n     (rst_n),
    .pressed   (pressed),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk_1000hz = ~clk_1000hz;

  typedef struct {
    logic [15:0] p;
    logic        r;
    logic        v;
    logic [3:0]  c;
    logic        b;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] p, input logic r, input logic v, input logic [3:0] c,
                     input logic b, input logic o);
    vec_t t;
    t.p = p; t.r = r; t.v = v; t.c = c; t.b = b; t.o = o;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [15:0] p, input logic r);
    pressed   = p;
    key_ready = r;
    @(posedge clk_1000hz);
    #1;
  endtask

  logic [11:0] rep_mask;
  logic [11:0] rep_exp;

  initial begin
    rst_n     = 1'b0;
    pressed   = '0;
    key_ready = 1'b0;
    #12;
    chk("reset_valid", 32'(key_valid), 32'd0);
    chk("reset_code",  32'(key_code),  32'd0);
    chk("reset_ovf",   32'(overflow),  32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    @(negedge clk_1000hz);
    rst_n = 1'b1;

    // T1 single press and pop
    add(16'h0000, 0, 0, 0, 0, 0);
    add(16'h0020, 0, 1, 5, 1, 0);
    add(16'h0020, 1, 0, 0, 1, 0);
    add(16'h0000, 0, 0, 0, 0, 0);
    // T2 simultaneous rise, lock-out, wait-all
    add(16'h0208, 0, 1, 3, 1, 0);
    add(16'h020a, 0, 1, 3, 1, 0);
    add(16'h0202, 0, 1, 3, 1, 0);
    add(16'h0200, 0, 1, 3, 1, 0);
    add(16'h0000, 0, 1, 3, 0, 0);
    add(16'h0000, 1, 0, 0, 0, 0);
    // T4 fill with 10..13, then push 7 while popping a full FIFO
    add(16'h0400, 0, 1, 10, 1, 0);
    add(16'h0000, 0, 1, 10, 0, 0);
    add(16'h0800, 0, 1, 10, 1, 0);
    add(16'h0000, 0, 1, 10, 0, 0);
    add(16'h1000, 0, 1, 10, 1, 0);
    add(16'h0000, 0, 1, 10, 0, 0);
    add(16'h2000, 0, 1, 10, 1, 0);
    add(16'h0000, 0, 1, 10, 0, 0);
    add(16'h0080, 1, 1, 11, 1, 0);
    add(16'h0000, 1, 1, 12, 0, 0);
    add(16'h0000, 1, 1, 13, 0, 0);
    add(16'h0000, 1, 1, 7,  0, 0);
    add(16'h0000, 1, 0, 0,  0, 0);
    // T3 five presses into a depth-4 FIFO, then drain
    add(16'h0001, 0, 1, 0, 1, 0);
    add(16'h0000, 0, 1, 0, 0, 0);
    add(16'h0002, 0, 1, 0, 1, 0);
    add(16'h0000, 0, 1, 0, 0, 0);
    add(16'h0004, 0, 1, 0, 1, 0);
    add(16'h0000, 0, 1, 0, 0, 0);
    add(16'h0008, 0, 1, 0, 1, 0);
    add(16'h0000, 0, 1, 0, 0, 0);
    add(16'h0010, 0, 1, 0, 1, 1);
    add(16'h0000, 0, 1, 0, 0, 1);
    add(16'h0000, 1, 1, 1, 0, 1);
    add(16'h0000, 1, 1, 2, 0, 1);
    add(16'h0000, 1, 1, 3, 0, 1);
    add(16'h0000, 1, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].p, vecs[i].r);
      chk($sformatf("vec%0d_valid", i), 32'(key_valid), 32'(vecs[i].v));
      if (vecs[i].v) chk($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].c));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].b));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].o));
    end

    // T5 asynchronous reset while held with two entries queued
    step(16'h0040, 0);
    step(16'h0000, 0);
    step(16'h0100, 0);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_code", 32'(key_code), 32'd6);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(key_valid), 32'd0);
    chk("t5_rst_busy",  32'(busy),      32'd0);
    chk("t5_rst_ovf",   32'(overflow),  32'd0);
    chk("t5_rst_code",  32'(key_code),  32'd0);
    @(negedge clk_1000hz);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(16'h0100, 0);
      chk($sformatf("t5_held%0d_valid", i), 32'(key_valid), 32'd0);
    end
    step(16'h0000, 0);
    chk("t5_rel_valid", 32'(key_valid), 32'd0);
    chk("t5_rel_busy",  32'(busy),      32'd0);
    step(16'h0100, 0);
    chk("t5_repress_valid", 32'(key_valid), 32'd1);
    chk("t5_repress_code",  32'(key_code),  32'd8);
    step(16'h0100, 1);
    chk("t5_pop_valid", 32'(key_valid), 32'd0);
    step(16'h0000, 1);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // T6 hold key 2 for 12 clocks with the consumer always ready
    rep_mask = '0;
    for (int i = 0; i < 12; i++) begin
      step(16'h0004, 1);
      if (key_valid) begin
        rep_mask[i] = 1'b1;
        chk($sformatf("t6_code%0d", i), 32'(key_code), 32'd2);
      end
    end
    step(16'h0000, 1);
`ifdef KEY_REPEAT_EN
    rep_exp = 12'b1001_0010_0001;
`else
    rep_exp = 12'b0000_0000_0001;
`endif
    chk("t6_push_clocks", 32'(rep_mask), 32'(rep_exp));
    chk("t6_ovf",  32'(overflow), 32'd0);
    chk("t6_busy", 32'(busy),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
